// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU data-port to memory-bus bridge.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } bridge_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mips_data_bridge_if.sv
// Pipelined memory-bus signal bundle between the bridge (master) and memory (slave).
interface mips_data_bridge_if;
  // Handshake: a command (bus_read or bus_write with address/data) is presented by
  // the master and held stable until a cycle where bus_waitrequest=0, which is the
  // cycle it is accepted. Read data arrives on any later or the same cycle, qualified
  // by bus_readdatavalid; the slave may not stall a response.
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic        bus_readdatavalid;
  logic [31:0] bus_readdata;

  modport master (
    output bus_address, bus_read, bus_write, bus_writedata,
    input  bus_waitrequest, bus_readdatavalid, bus_readdata
  );

  modport slave (
    input  bus_address, bus_read, bus_write, bus_writedata,
    output bus_waitrequest, bus_readdatavalid, bus_readdata
  );
endinterface

// File: rtl/mips_data_bridge_timeout.sv
// Cycle counter that flags an expired bus transaction after TIMEOUT_CYCLES cycles of run.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th running cycle so the FSM leaves at that edge.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/mips_data_bridge.sv
// Converts the CPU's combinational data access into a stalled, pipelined bus transaction
// with misalignment, illegal-access and timeout detection.
module mips_data_bridge
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [31:0]         cpu_writedata,
  output logic [31:0]         cpu_readdata,
  output logic                cpu_stall,
  mips_data_bridge_if.master  bus,
  output logic                bus_error,
  output logic [31:0]         stall_count,
  output bridge_state_t       dbg_state
);

  bridge_state_t state, state_d;

  logic        bus_read_q, bus_write_q;
  logic [31:0] bus_address_q, bus_writedata_q;
  logic [31:0] cpu_readdata_q;
  logic        bus_error_q;
  logic [31:0] stall_count_q;

  logic cpu_req;
  logic issue_cmd;
  logic capture;
  logic tmo_run, tmo_clear, tmo_expired;

  assign cpu_req   = cpu_read | cpu_write;
  assign tmo_run   = (state == ISSUE) || (state == WAIT_DATA);
  assign tmo_clear = (state == IDLE);

  bus_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .run     (tmo_run),
    .clear   (tmo_clear),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d   = state;
    cpu_stall = 1'b1;
    issue_cmd = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req) begin
          if ((cpu_read && cpu_write) || !is_word_aligned(cpu_address)) begin
            state_d = ERROR;
          end else begin
            state_d   = ISSUE;
            issue_cmd = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!bus.bus_waitrequest) begin
          if (bus_read_q) begin
            if (bus.bus_readdatavalid) begin
              capture = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WAIT_DATA;
            end
          end else begin
            state_d = DONE;
          end
        end
        // Completion wins over a timeout landing in the same cycle.
        if (tmo_expired && state_d != DONE) begin
          state_d = ERROR;
        end
      end
      WAIT_DATA: begin
        if (bus.bus_readdatavalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (tmo_expired) begin
          state_d = ERROR;
        end
      end
      DONE: begin
        cpu_stall = 1'b0;
        state_d   = IDLE;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Commands stay asserted only while the next state is ISSUE; any other exit drops them.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_read_q      <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= '0;
      bus_writedata_q <= '0;
    end else begin
      if (state_d != ISSUE) begin
        bus_read_q  <= 1'b0;
        bus_write_q <= 1'b0;
      end else if (issue_cmd) begin
        bus_read_q  <= cpu_read;
        bus_write_q <= cpu_write;
      end
      if (issue_cmd) begin
        bus_address_q   <= {cpu_address[31:2], 2'b00};
        bus_writedata_q <= cpu_writedata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_readdata_q <= '0;
      bus_error_q    <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      if (capture) begin
        cpu_readdata_q <= bus.bus_readdata;
      end
      if (state_d == ERROR) begin
        bus_error_q <= 1'b1;
      end
      if (cpu_stall && stall_count_q != 32'hFFFF_FFFF) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign bus.bus_read      = bus_read_q;
  assign bus.bus_write     = bus_write_q;
  assign bus.bus_address   = bus_address_q;
  assign bus.bus_writedata = bus_writedata_q;
  assign cpu_readdata      = cpu_readdata_q;
  assign bus_error         = bus_error_q;
  assign stall_count       = stall_count_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_mips_data_bridge.sv
// Randomized bench for mips_data_bridge: a bus slave with a word memory, and a
// CPU-side reference memory predicting read data and total stall cycles.
module tb_mips_data_bridge;
  import mips_bus_pkg::*;

  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cpu_address = '0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [31:0]   cpu_writedata = '0;
  logic [31:0]   cpu_readdata;
  logic          cpu_stall;
  logic          bus_error;
  logic [31:0]   stall_count;
  bridge_state_t dbg_state;

  mips_data_bridge_if bus();

  mips_data_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_address   (cpu_address),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_stall     (cpu_stall),
    .bus           (bus),
    .bus_error     (bus_error),
    .stall_count   (stall_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] exp_stall = '0;
  logic [31:0] last_rd = '0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the bridge idle; returns at posedge+1 back in IDLE.
  // w = waitrequest cycles before accept, lat = cycles from accept to read data.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int w, input int lat);
    logic [31:0] exp_rd;
    cpu_read = !wr;
    cpu_write = wr;
    cpu_address = addr;
    cpu_writedata = wdata;
    bus.bus_waitrequest = 1'b1;
    bus.bus_readdatavalid = 1'b0;
    if (wr) ref_mem[addr] = wdata;
    else exp_q.push_back(ref_rd(addr));
    exp_stall += 32'(2 + w + (wr ? 0 : lat));
    @(negedge clk);
    check32("idle_stall", cpu_stall, 1);
    @(posedge clk); #1;
    for (int i = 0; i <= w; i++) begin
      bus.bus_waitrequest = (i < w);
      bus.bus_readdatavalid = (i == w) && !wr && (lat == 0);
      bus.bus_readdata = slave_rd(bus.bus_address);
      @(negedge clk);
      check32("issue_state", dbg_state, ISSUE);
      check32("issue_stall", cpu_stall, 1);
      check32("bus_read", bus.bus_read, !wr);
      check32("bus_write", bus.bus_write, wr);
      check32("bus_address", bus.bus_address, addr);
      if (wr) check32("bus_writedata", bus.bus_writedata, wdata);
      if (wr && i == w) slave_mem[bus.bus_address] = bus.bus_writedata;
      @(posedge clk); #1;
    end
    bus.bus_waitrequest = 1'b1;
    bus.bus_readdatavalid = 1'b0;
    if (!wr) begin
      for (int j = 1; j <= lat; j++) begin
        bus.bus_readdatavalid = (j == lat);
        bus.bus_readdata = slave_rd(bus.bus_address);
        @(negedge clk);
        check32("wait_state", dbg_state, WAIT_DATA);
        check32("wait_stall", cpu_stall, 1);
        check32("wait_bus_read", bus.bus_read, 0);
        @(posedge clk); #1;
      end
    end
    bus.bus_readdatavalid = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    check32("done_state", dbg_state, DONE);
    check32("done_stall", cpu_stall, 0);
    if (!wr) begin
      exp_rd = exp_q.pop_front();
      last_rd = exp_rd;
      check32("read_data", cpu_readdata, exp_rd);
    end else begin
      check32("readdata_hold", cpu_readdata, last_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset_and_check(input string tag);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_stall = '0;
    last_rd = '0;
    @(negedge clk);
    check32({tag, "_rst_state"}, dbg_state, IDLE);
    check32({tag, "_rst_error"}, bus_error, 0);
    check32({tag, "_rst_stall"}, cpu_stall, 0);
    check32({tag, "_rst_count"}, stall_count, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_error(input bit rd, input bit wr, input logic [31:0] addr, input string tag);
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_writedata = 32'h55AA_55AA;
    @(negedge clk);
    check32({tag, "_req_stall"}, cpu_stall, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32({tag, "_state"}, dbg_state, ERROR);
      check32({tag, "_bus_error"}, bus_error, 1);
      check32({tag, "_stall"}, cpu_stall, 1);
      check32({tag, "_no_read"}, bus.bus_read, 0);
      check32({tag, "_no_write"}, bus.bus_write, 0);
      @(posedge clk); #1;
    end
    apply_reset_and_check(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.bus_waitrequest = 1'b1;
    bus.bus_readdatavalid = 1'b0;
    bus.bus_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check32("reset_state", dbg_state, IDLE);
    check32("reset_bus_read", bus.bus_read, 0);
    check32("reset_bus_write", bus.bus_write, 0);
    check32("reset_bus_address", bus.bus_address, 0);
    check32("reset_bus_writedata", bus.bus_writedata, 0);
    check32("reset_readdata", cpu_readdata, 0);
    check32("reset_error", bus_error, 0);
    check32("reset_stall", cpu_stall, 0);
    check32("reset_count", stall_count, 0);
    @(posedge clk); #1;

    // Directed: single write, 1-cycle-latency read, read accepted after 3 waits.
    do_access(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    check32("write_stall_count", stall_count, 32'd2);
    @(posedge clk); #1;
    ref_mem[32'h0000_2004] = 32'h1234_5678;
    slave_mem[32'h0000_2004] = 32'h1234_5678;
    do_access(1'b0, 32'h0000_2004, 32'h0, 0, 1);
    do_access(1'b0, 32'h0000_2004, 32'h0, 3, 0);
    @(negedge clk);
    check32("directed_stall_count", stall_count, exp_stall);
    @(posedge clk); #1;

    // Random back-to-back and spaced traffic within the timeout budget.
    for (int n = 0; n < 40; n++) begin
      do_access(1'($urandom_range(0, 1)),
                32'h0000_1000 + (32'($urandom_range(0, 15)) << 2),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check32("idle_no_req", cpu_stall, 0);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check32("random_stall_count", stall_count, exp_stall);
    @(posedge clk); #1;

    // Misaligned and illegal read+write.
    do_error(1'b1, 1'b0, 32'h0000_2006, "misaligned");
    do_error(1'b1, 1'b1, 32'h0000_2000, "rd_wr");

    // Timeout with waitrequest stuck high.
    cpu_read = 1'b1;
    cpu_address = 32'h0000_1010;
    bus.bus_waitrequest = 1'b1;
    bus.bus_readdatavalid = 1'b0;
    @(negedge clk);
    check32("tmo_idle_stall", cpu_stall, 1);
    @(posedge clk); #1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check32("tmo_issue_state", dbg_state, ISSUE);
      check32("tmo_bus_read", bus.bus_read, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check32("tmo_state", dbg_state, ERROR);
    check32("tmo_bus_read_drop", bus.bus_read, 0);
    check32("tmo_bus_error", bus_error, 1);
    check32("tmo_stall", cpu_stall, 1);
    @(posedge clk); #1;
    apply_reset_and_check("tmo");

    // Reset while waiting for read data, then a stale response.
    cpu_read = 1'b1;
    cpu_address = 32'h0000_1020;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_waitrequest = 1'b0;
    @(negedge clk);
    check32("rst_mid_issue", dbg_state, ISSUE);
    @(posedge clk); #1;
    bus.bus_waitrequest = 1'b1;
    cpu_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check32("rst_mid_wait", dbg_state, WAIT_DATA);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.bus_readdatavalid = 1'b1;
    bus.bus_readdata = 32'hCAFE_F00D;
    @(negedge clk);
    check32("rst_mid_state", dbg_state, IDLE);
    check32("rst_mid_stall", cpu_stall, 0);
    check32("rst_mid_bus_read", bus.bus_read, 0);
    @(posedge clk); #1;
    bus.bus_readdatavalid = 1'b0;
    @(negedge clk);
    check32("rst_stale_state", dbg_state, IDLE);
    check32("rst_stale_readdata", cpu_readdata, 0);
    check32("rst_stale_count", stall_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
